tick_period_checker: RTL

- Receive-side monitor for a periodic single-cycle tick produced by the team's free-running delay/period generators.
- Measures the interval between consecutive ticks against an expected period with tolerance. Locks after a run of good intervals and flags early and late (missing) ticks.
- Sits downstream of a tick generator. Its outputs feed status registers and liveness checks.

---
 rtl/tick_period_checker_if.sv | 23 ++
 rtl/tick_period_checker.sv | 135 +++++++++++++
 2 files changed

// File: rtl/tick_period_checker_if.sv
// Tick input and status outputs of tick_period_checker.
// The master modport drives the tick; the slave modport is the checker side.
interface tick_period_checker_if #(
    parameter int CBITS = 15,
    parameter int ERR_W = 8
) ();
    logic             tick_in;
    logic             locked;
    logic             early_err;
    logic             late_err;
    logic [ERR_W-1:0] err_cnt;
    logic [CBITS-1:0] period_meas;

    modport master (
        output tick_in,
        input  locked, early_err, late_err, err_cnt, period_meas
    );

    modport slave (
        input  tick_in,
        output locked, early_err, late_err, err_cnt, period_meas
    );
endinterface

// File: rtl/tick_period_checker.sv
// Receive-side tick monitor: measures tick-to-tick intervals against
// PERIOD +/- TOL, locks after LOCK_CNT good intervals, flags early/late ticks.
module tick_period_checker #(
    parameter int PERIOD   = 17501,
    parameter int TOL      = 0,
    parameter int CBITS    = 15,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tick_period_checker_if.slave bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [CBITS-1:0] LO_C   = CBITS'(PERIOD - TOL);
    localparam logic [CBITS-1:0] HI_C   = CBITS'(PERIOD + TOL);
    localparam logic [CBITS-1:0] SAT_C  = CBITS'(PERIOD + TOL + 1);
    localparam logic [GW-1:0]    LOCK_C = GW'(LOCK_CNT);

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK, S_LOST} state_e;

    state_e           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [GW-1:0]    good_q, good_d;
    logic             locked_q, locked_d;
    logic             early_q, early_d;
    logic             late_q, late_d;
    logic [ERR_W-1:0] errc_q, errc_d;
    logic [CBITS-1:0] pm_q, pm_d;

    logic             is_early;
    logic             in_win;
    logic             post_late;
    logic [GW-1:0]    good_inc;

    assign is_early  = cnt_q < LO_C;
    assign in_win    = !is_early && (cnt_q <= HI_C);
    // cnt only reaches the saturation value after a late event has fired
    assign post_late = cnt_q > HI_C;
    assign good_inc  = good_q + GW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        good_d  = good_q;
        early_d = 1'b0;
        late_d  = 1'b0;
        errc_d  = errc_q;
        pm_d    = pm_q;

        if (bus.tick_in) begin
            cnt_d = CBITS'(1);
        end else if (cnt_q < SAT_C) begin
            cnt_d = cnt_q + CBITS'(1);
        end

        if (bus.tick_in) begin
            if (state_q != S_IDLE && !post_late) begin
                pm_d = cnt_q;
            end
            case (state_q)
                S_IDLE: begin
                    state_d = S_ACQ;
                    good_d  = '0;
                end
                S_ACQ: begin
                    if (post_late) begin
                        good_d = '0;
                    end else if (in_win) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_C) begin
                            state_d = S_LOCK;
                        end
                    end else begin
                        early_d = 1'b1;
                        good_d  = '0;
                    end
                end
                S_LOCK: begin
                    if (!in_win) begin
                        early_d = is_early;
                        state_d = S_LOST;
                    end
                end
                S_LOST: begin
                    state_d = S_ACQ;
                    good_d  = '0;
                end
            endcase
        end else if (cnt_q == HI_C) begin
            late_d = 1'b1;
            if (state_q == S_ACQ) begin
                good_d = '0;
            end
            if (state_q == S_LOCK) begin
                state_d = S_LOST;
            end
        end

        if ((early_d || late_d) && (errc_q != '1)) begin
            errc_d = errc_q + ERR_W'(1);
        end

        locked_d = (state_d == S_LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            early_q  <= 1'b0;
            late_q   <= 1'b0;
            errc_q   <= '0;
            pm_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            early_q  <= early_d;
            late_q   <= late_d;
            errc_q   <= errc_d;
            pm_q     <= pm_d;
        end
    end

    assign bus.locked      = locked_q;
    assign bus.early_err   = early_q;
    assign bus.late_err    = late_q;
    assign bus.err_cnt     = errc_q;
    assign bus.period_meas = pm_q;
endmodule
